decode_pipeline_controller: RTL and testbench
=============================================

Name: decode_pipeline_controller

Overview:
Hazard and sequencing controller for the decode/execute pipeline register that carries the decoded control bundle (forwarding selects, wren, writeAd, PC_load and the rest). Each cycle it decides whether that register and the fetch/decode stages advance, hold, or load a NOP bubble. It generates the One_A/One_B (forward from execute) and Two_A/Two_B (forward from memory) operand selects that the register captures. It also sequences branch-flush penalty cycles and memory-busy freezes.

Parameters:
FLUSH_CYCLES, 2, bubble cycles inserted after a taken branch (>=1)
LOAD_STALL_CYCLES, 1, bubble cycles inserted on a load-use hazard (>=1)
CNT_W, 16, width of stall statistics counter

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
dec_valid  in  1  decode stage holds a real instruction
dec_rs_a  in  3  decode source register A address
dec_rs_b  in  3  decode source register B address
dec_uses_a  in  1  instruction reads operand A
dec_uses_b  in  1  instruction reads operand B
ex_wren  in  1  execute-stage instruction writes a register
ex_writeAd  in  3  execute-stage destination
ex_is_load  in  1  execute-stage instruction is a memory load
mem_wren  in  1  memory-stage instruction writes a register
mem_writeAd  in  3  memory-stage destination
branch_taken  in  1  execute stage asserts PC_load (taken branch/jump)
mem_busy  in  1  data memory not ready; whole pipe must freeze
pipe_en  out  1  PC, fetch and decode register load enable
bubble  out  1  decode/execute register loads NOP (wren, write, PC_load forced 0)
flush  out  1  kill instruction in fetch/decode
One_A  out  1  operand A from execute result
One_B  out  1  operand B from execute result
Two_A  out  1  operand A from memory-stage result
Two_B  out  1  operand B from memory-stage result
state  out  2  RUN=0, STALL=1, FLUSH=2, WAIT=3
stall_count  out  CNT_W  saturating count of cycles with pipe_en=0 and RST=0

Behaviour:
- Outputs combinational from current state, counter and inputs; state, counter and stall_count registered.
- RST high (any state, mid-sequence included): next state RUN, counter 0, stall_count 0. While RST high: pipe_en=0, bubble=1, flush=0, all forwarding selects 0.
- Forwarding (every state): matchEA = dec_uses_a & ex_wren & ex_writeAd==dec_rs_a; matchMA = dec_uses_a & mem_wren & mem_writeAd==dec_rs_a; likewise for B. One_A = matchEA & !ex_is_load. Two_A = matchMA & !matchEA (execute has priority). Same rule for B. Register 0 is not special.
- load_use = dec_valid & ex_is_load & (matchEA | matchEB).
- Priority in RUN: branch_taken > mem_busy > load_use > normal.
- RUN, normal: pipe_en=1, bubble=0, flush=0.
- RUN, branch_taken: pipe_en=1, bubble=1, flush=1. If FLUSH_CYCLES>1: go FLUSH, counter=FLUSH_CYCLES-2. Else stay RUN.
- RUN, mem_busy: pipe_en=0, bubble=0, flush=0; go WAIT.
- RUN, load_use: pipe_en=0, bubble=1, flush=0. If LOAD_STALL_CYCLES>1: go STALL, counter=LOAD_STALL_CYCLES-2. Else stay RUN.
- STALL: pipe_en=0, bubble=1. Counter 0 -> RUN, else decrement. mem_busy high: all outputs as WAIT, counter holds, state holds.
- FLUSH: pipe_en=1, bubble=1, flush=1. Counter 0 -> RUN, else decrement. branch_taken ignored (only bubbles in execute). mem_busy high: pipe_en=0, counter and state hold.
- WAIT: pipe_en=0, bubble=0, flush=0. Everything frozen. branch_taken/load_use ignored (re-presented after unfreeze). mem_busy low -> RUN; RUN rules apply next cycle.
- stall_count increments when pipe_en=0 and RST=0, saturates at all-ones.

Test Plan:
- RST 2 cycles, then dec_rs_a=3, dec_uses_a=1, ex_wren=1, ex_writeAd=3, ex_is_load=0 -> One_A=1, Two_A=0, pipe_en=1, bubble=0, state=0.
- Same, plus mem_wren=1, mem_writeAd=3 -> One_A=1, Two_A=0. Change ex_writeAd=5 -> One_A=0, Two_A=1.
- Defaults: ex_is_load=1, ex_writeAd=2, dec_rs_b=2, dec_uses_b=1, dec_valid=1 for one cycle -> that cycle pipe_en=0, bubble=1, One_B=0; next cycle state=0; stall_count=1.
- branch_taken 1 cycle, FLUSH_CYCLES=2 -> flush=bubble=1 for 2 consecutive cycles, state RUN,FLUSH,RUN; second branch_taken in FLUSH ignored.
- mem_busy high 3 cycles during FLUSH (counter=0) -> pipe_en=0 for 3 cycles, state stays FLUSH; then 1 flush cycle, RUN.
- RST asserted in STALL (LOAD_STALL_CYCLES=3) -> next cycle state=0, stall_count=0, outputs normal.

Source files
------------

// File: rtl/decode_pipeline_controller.sv
// Hazard/sequencing controller for the decode/execute pipeline register: operand
// forwarding selects, load-use bubbles, branch flush penalty and memory-busy freeze.
module decode_pipeline_controller #(
  parameter int FLUSH_CYCLES      = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             dec_valid,
  input  logic [2:0]       dec_rs_a,
  input  logic [2:0]       dec_rs_b,
  input  logic             dec_uses_a,
  input  logic             dec_uses_b,
  input  logic             ex_wren,
  input  logic [2:0]       ex_writeAd,
  input  logic             ex_is_load,
  input  logic             mem_wren,
  input  logic [2:0]       mem_writeAd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pipe_en,
  output logic             bubble,
  output logic             flush,
  output logic             One_A,
  output logic             One_B,
  output logic             Two_A,
  output logic             Two_B,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // The penalty counter holds "remaining cycles minus one" once the sequence
  // has left RUN, so its largest value is max(FLUSH, LOAD_STALL) - 2.
  localparam int MAX_PEN = (FLUSH_CYCLES > LOAD_STALL_CYCLES) ? FLUSH_CYCLES : LOAD_STALL_CYCLES;
  localparam int CTR_W   = (MAX_PEN > 2) ? $clog2(MAX_PEN - 1) : 1;
  localparam logic [CTR_W-1:0] FLUSH_INIT = CTR_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
  localparam logic [CTR_W-1:0] STALL_INIT = CTR_W'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);

  state_t            state_reg, state_next;
  logic [CTR_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  stall_count_reg;

  logic [1:0][2:0]   rs_vec;
  logic [1:0]        uses_vec;
  logic [1:0]        match_ex;
  logic [1:0]        match_mem;
  logic [1:0]        fwd_one;
  logic [1:0]        fwd_two;
  logic              load_use;

  assign rs_vec   = {dec_rs_b, dec_rs_a};
  assign uses_vec = {dec_uses_b, dec_uses_a};

  // Index 0 is operand A, index 1 is operand B; execute result wins over memory.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign match_ex[gi]  = uses_vec[gi] & ex_wren  & (ex_writeAd  == rs_vec[gi]);
      assign match_mem[gi] = uses_vec[gi] & mem_wren & (mem_writeAd == rs_vec[gi]);
      assign fwd_one[gi]   = ~RST & match_ex[gi] & ~ex_is_load;
      assign fwd_two[gi]   = ~RST & match_mem[gi] & ~match_ex[gi];
    end
  endgenerate

  assign One_A    = fwd_one[0];
  assign One_B    = fwd_one[1];
  assign Two_A    = fwd_two[0];
  assign Two_B    = fwd_two[1];
  assign load_use = dec_valid & ex_is_load & (|match_ex);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pipe_en    = 1'b0;
    bubble     = 1'b0;
    flush      = 1'b0;
    if (RST) begin
      bubble     = 1'b1;
      state_next = RUN;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (branch_taken) begin
            pipe_en = 1'b1;
            bubble  = 1'b1;
            flush   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next = FLUSH;
              cnt_next   = FLUSH_INIT;
            end
          end else if (mem_busy) begin
            state_next = WAIT;
          end else if (load_use) begin
            bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_next = STALL;
              cnt_next   = STALL_INIT;
            end
          end else begin
            pipe_en = 1'b1;
          end
        end
        STALL: begin
          // A memory freeze looks exactly like WAIT and leaves the count untouched.
          if (!mem_busy) begin
            bubble = 1'b1;
            if (cnt_reg == '0) state_next = RUN;
            else               cnt_next   = cnt_reg - CTR_W'(1);
          end
        end
        FLUSH: begin
          bubble = 1'b1;
          flush  = 1'b1;
          if (!mem_busy) begin
            pipe_en = 1'b1;
            if (cnt_reg == '0) state_next = RUN;
            else               cnt_next   = cnt_reg - CTR_W'(1);
          end
        end
        WAIT: begin
          if (!mem_busy) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    state_reg <= state_next;
    cnt_reg   <= cnt_next;
    if (RST) begin
      stall_count_reg <= '0;
    end else if (!pipe_en && (stall_count_reg != {CNT_W{1'b1}})) begin
      stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign state       = state_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_decode_pipeline_controller.sv
// Directed scenarios plus randomized traffic against a penalty-accounting reference
// model, run on two parameterizations of decode_pipeline_controller.
module tb_decode_pipeline_controller;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dec_valid, dec_uses_a, dec_uses_b;
  logic [2:0]  dec_rs_a, dec_rs_b, ex_writeAd, mem_writeAd;
  logic        ex_wren, ex_is_load, mem_wren, branch_taken, mem_busy;

  logic        pipe_en, bubble, flush, One_A, One_B, Two_A, Two_B;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic        pipe_en_3, bubble_3, flush_3, One_A_3, One_B_3, Two_A_3, Two_B_3;
  logic [1:0]  state_3;
  logic [15:0] stall_count_3;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  decode_pipeline_controller #(.FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(1), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .dec_valid(dec_valid), .dec_rs_a(dec_rs_a), .dec_rs_b(dec_rs_b),
    .dec_uses_a(dec_uses_a), .dec_uses_b(dec_uses_b), .ex_wren(ex_wren), .ex_writeAd(ex_writeAd),
    .ex_is_load(ex_is_load), .mem_wren(mem_wren), .mem_writeAd(mem_writeAd),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pipe_en(pipe_en), .bubble(bubble),
    .flush(flush), .One_A(One_A), .One_B(One_B), .Two_A(Two_A), .Two_B(Two_B),
    .state(state), .stall_count(stall_count));

  decode_pipeline_controller #(.FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(3), .CNT_W(16)) dut3 (
    .CLK(CLK), .RST(RST), .dec_valid(dec_valid), .dec_rs_a(dec_rs_a), .dec_rs_b(dec_rs_b),
    .dec_uses_a(dec_uses_a), .dec_uses_b(dec_uses_b), .ex_wren(ex_wren), .ex_writeAd(ex_writeAd),
    .ex_is_load(ex_is_load), .mem_wren(mem_wren), .mem_writeAd(mem_writeAd),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pipe_en(pipe_en_3), .bubble(bubble_3),
    .flush(flush_3), .One_A(One_A_3), .One_B(One_B_3), .Two_A(Two_A_3), .Two_B(Two_B_3),
    .state(state_3), .stall_count(stall_count_3));

  logic [6:0]  out_v [2];
  logic [1:0]  st_v  [2];
  logic [15:0] sc_v  [2];
  assign out_v[0] = {pipe_en, bubble, flush, One_A, One_B, Two_A, Two_B};
  assign out_v[1] = {pipe_en_3, bubble_3, flush_3, One_A_3, One_B_3, Two_A_3, Two_B_3};
  assign st_v[0]  = state;
  assign st_v[1]  = state_3;
  assign sc_v[0]  = stall_count;
  assign sc_v[1]  = stall_count_3;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    RST = 1'b0; dec_valid = 1'b0; dec_rs_a = 3'd0; dec_rs_b = 3'd0;
    dec_uses_a = 1'b0; dec_uses_b = 1'b0; ex_wren = 1'b0; ex_writeAd = 3'd0;
    ex_is_load = 1'b0; mem_wren = 1'b0; mem_writeAd = 3'd0;
    branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    RST = 1'b1; dec_uses_a = 1'b1; dec_rs_a = 3'd1; ex_wren = 1'b1; ex_writeAd = 3'd1;
    mem_wren = 1'b1; mem_writeAd = 3'd1;
    tick(); tick();
    @(negedge CLK);
    checks++;
    if ({pipe_en, bubble, flush, One_A, Two_A} !== 5'b01000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 01000", {pipe_en, bubble, flush, One_A, Two_A});
    end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    set_idle();
    tick();
    @(negedge CLK);
    checks++;
    if (stall_count !== 16'd0 || stall_count_3 !== 16'd0) begin
      errors++; $display("FAIL reset_stall_count: got %0d/%0d expected 0/0", stall_count, stall_count_3);
    end
    checks++;
    if ({pipe_en, bubble, flush} !== 3'b100) begin
      errors++; $display("FAIL reset_release: got %b expected 100", {pipe_en, bubble, flush});
    end
    $display("test_reset: stall_count=%0d state=%0d", stall_count, state);
  endtask

  task automatic test_forwarding();
    set_idle();
    dec_rs_a = 3'd3; dec_uses_a = 1'b1; ex_wren = 1'b1; ex_writeAd = 3'd3;
    @(negedge CLK);
    checks++;
    if ({One_A, Two_A, pipe_en, bubble, state} !== 6'b101000) begin
      errors++; $display("FAIL fwd_ex: got %b expected 101000", {One_A, Two_A, pipe_en, bubble, state});
    end
    mem_wren = 1'b1; mem_writeAd = 3'd3;
    #1;
    checks++;
    if ({One_A, Two_A} !== 2'b10) begin errors++; $display("FAIL fwd_priority: got %b expected 10", {One_A, Two_A}); end
    ex_writeAd = 3'd5;
    #1;
    checks++;
    if ({One_A, Two_A} !== 2'b01) begin errors++; $display("FAIL fwd_mem: got %b expected 01", {One_A, Two_A}); end
    // Operand B from memory, with operand A matching a load that is not a real instruction.
    dec_rs_b = 3'd3; dec_uses_b = 1'b1; ex_writeAd = 3'd0; dec_rs_a = 3'd0; ex_is_load = 1'b1;
    #1;
    checks++;
    if ({One_A, Two_A, One_B, Two_B, pipe_en} !== 5'b00011) begin
      errors++; $display("FAIL fwd_load_b: got %b expected 00011", {One_A, Two_A, One_B, Two_B, pipe_en});
    end
    $display("test_forwarding: One_A=%b Two_A=%b One_B=%b Two_B=%b", One_A, Two_A, One_B, Two_B);
    set_idle();
    tick();
  endtask

  task automatic test_load_use();
    set_idle();
    ex_is_load = 1'b1; ex_writeAd = 3'd2; ex_wren = 1'b1; dec_rs_b = 3'd2; dec_uses_b = 1'b1; dec_valid = 1'b1;
    @(negedge CLK);
    checks++;
    if ({pipe_en, bubble, One_B} !== 3'b010) begin
      errors++; $display("FAIL load_use_bubble: got %b expected 010", {pipe_en, bubble, One_B});
    end
    tick();
    set_idle();
    @(negedge CLK);
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL load_use_state: got %0d expected 0", state); end
    checks++;
    if (stall_count !== 16'd1) begin errors++; $display("FAIL load_use_count: got %0d expected 1", stall_count); end
    $display("test_load_use: state=%0d stall_count=%0d", state, stall_count);
    tick();
  endtask

  task automatic test_branch_flush();
    set_idle();
    branch_taken = 1'b1;
    @(negedge CLK);
    checks++;
    if ({pipe_en, bubble, flush, state} !== 5'b11100) begin
      errors++; $display("FAIL branch_first: got %b expected 11100", {pipe_en, bubble, flush, state});
    end
    tick();
    @(negedge CLK);
    checks++;
    if ({pipe_en, bubble, flush, state} !== 5'b11110) begin
      errors++; $display("FAIL branch_second: got %b expected 11110", {pipe_en, bubble, flush, state});
    end
    tick();
    branch_taken = 1'b0;
    @(negedge CLK);
    checks++;
    if ({pipe_en, bubble, flush, state} !== 5'b10000) begin
      errors++; $display("FAIL branch_done: got %b expected 10000", {pipe_en, bubble, flush, state});
    end
    $display("test_branch_flush: state=%0d flush=%b", state, flush);
    tick();
  endtask

  task automatic test_busy_in_flush();
    set_idle();
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if ({pipe_en, state} !== 3'b010) begin
        errors++; $display("FAIL busy_flush_freeze%0d: got %b expected 010", i, {pipe_en, state});
      end
      tick();
    end
    mem_busy = 1'b0;
    @(negedge CLK);
    checks++;
    if ({pipe_en, bubble, flush, state} !== 5'b11110) begin
      errors++; $display("FAIL busy_flush_resume: got %b expected 11110", {pipe_en, bubble, flush, state});
    end
    checks++;
    if (stall_count !== 16'd4) begin errors++; $display("FAIL busy_flush_count: got %0d expected 4", stall_count); end
    tick();
    @(negedge CLK);
    checks++;
    if ({flush, state} !== 3'b000) begin errors++; $display("FAIL busy_flush_end: got %b expected 000", {flush, state}); end
    $display("test_busy_in_flush: state=%0d stall_count=%0d", state, stall_count);
    tick();
  endtask

  task automatic test_reset_in_stall();
    set_idle();
    RST = 1'b1;
    tick();
    set_idle();
    ex_is_load = 1'b1; ex_writeAd = 3'd4; ex_wren = 1'b1; dec_rs_a = 3'd4; dec_uses_a = 1'b1; dec_valid = 1'b1;
    tick();
    set_idle();
    @(negedge CLK);
    checks++;
    if ({state_3, pipe_en_3, bubble_3} !== 4'b0101) begin
      errors++; $display("FAIL stall_entered: got %b expected 0101", {state_3, pipe_en_3, bubble_3});
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({state_3, pipe_en_3, bubble_3, flush_3} !== 5'b00100 || stall_count_3 !== 16'd0) begin
      errors++; $display("FAIL stall_reset: got %b cnt %0d expected 00100 cnt 0",
                         {state_3, pipe_en_3, bubble_3, flush_3}, stall_count_3);
    end
    $display("test_reset_in_stall: state=%0d stall_count=%0d", state_3, stall_count_3);
    tick();
  endtask

  // Reference model: tracks the kind of penalty in progress and how many penalty
  // cycles of that kind remain, rather than any counter encoding.
  task automatic test_random();
    int kind [2];
    int left [2];
    int sc   [2];
    int fc   [2];
    int lc   [2];
    bit mea, meb, mma, mmb, lu;
    logic [6:0] exp_out;
    bit epe, ebub, efl;
    fc[0] = 2; fc[1] = 3; lc[0] = 1; lc[1] = 3;
    set_idle();
    RST = 1'b1;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin kind[d] = 0; left[d] = 0; sc[d] = 0; end
    for (int n = 0; n < 600; n++) begin
      RST          = ($urandom_range(0, 59) == 0);
      dec_valid    = $urandom_range(0, 3) != 0;
      dec_rs_a     = 3'($urandom_range(0, 3));
      dec_rs_b     = 3'($urandom_range(0, 3));
      dec_uses_a   = $urandom_range(0, 1);
      dec_uses_b   = $urandom_range(0, 1);
      ex_wren      = $urandom_range(0, 3) != 0;
      ex_writeAd   = 3'($urandom_range(0, 3));
      ex_is_load   = $urandom_range(0, 2) == 0;
      mem_wren     = $urandom_range(0, 1);
      mem_writeAd  = 3'($urandom_range(0, 3));
      branch_taken = $urandom_range(0, 7) == 0;
      mem_busy     = $urandom_range(0, 5) == 0;
      @(negedge CLK);
      mea = dec_uses_a && ex_wren && (ex_writeAd == dec_rs_a);
      meb = dec_uses_b && ex_wren && (ex_writeAd == dec_rs_b);
      mma = dec_uses_a && mem_wren && (mem_writeAd == dec_rs_a);
      mmb = dec_uses_b && mem_wren && (mem_writeAd == dec_rs_b);
      lu  = dec_valid && ex_is_load && (mea || meb);
      for (int d = 0; d < 2; d++) begin
        epe = 0; ebub = 0; efl = 0;
        checks++;
        if (st_v[d] !== 2'(kind[d])) begin
          errors++; $display("FAIL rand_state dut%0d cyc%0d: got %0d expected %0d", d, n, st_v[d], kind[d]);
        end
        checks++;
        if (sc_v[d] !== 16'(sc[d])) begin
          errors++; $display("FAIL rand_count dut%0d cyc%0d: got %0d expected %0d", d, n, sc_v[d], sc[d]);
        end
        if (RST) begin
          ebub = 1; kind[d] = 0; left[d] = 0;
        end else if (kind[d] == 0) begin
          if (branch_taken) begin
            epe = 1; ebub = 1; efl = 1;
            if (fc[d] > 1) begin kind[d] = 2; left[d] = fc[d] - 1; end
          end else if (mem_busy) begin
            kind[d] = 3;
          end else if (lu) begin
            ebub = 1;
            if (lc[d] > 1) begin kind[d] = 1; left[d] = lc[d] - 1; end
          end else begin
            epe = 1;
          end
        end else if (kind[d] == 1) begin
          if (!mem_busy) begin
            ebub = 1; left[d]--;
            if (left[d] == 0) kind[d] = 0;
          end
        end else if (kind[d] == 2) begin
          ebub = 1; efl = 1;
          if (!mem_busy) begin
            epe = 1; left[d]--;
            if (left[d] == 0) kind[d] = 0;
          end
        end else begin
          if (!mem_busy) kind[d] = 0;
        end
        exp_out = {epe, ebub, efl,
                   !RST && mea && !ex_is_load, !RST && meb && !ex_is_load,
                   !RST && mma && !mea, !RST && mmb && !meb};
        checks++;
        if (out_v[d] !== exp_out) begin
          errors++; $display("FAIL rand_outputs dut%0d cyc%0d: got %b expected %b", d, n, out_v[d], exp_out);
        end
        if (RST) sc[d] = 0;
        else if (!epe && sc[d] < 65535) sc[d]++;
      end
      $display("rand cyc%0d rst=%b br=%b busy=%b lu=%b st=%0d/%0d out=%b/%b",
               n, RST, branch_taken, mem_busy, lu, st_v[0], st_v[1], out_v[0], out_v[1]);
      tick();
    end
  endtask

  initial begin
    set_idle();
    RST = 1'b1;
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_flush();
    test_busy_in_flush();
    test_reset_in_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
